disp_mux_gen: RTL

DISP_MUX_GEN -- requirements
Module: disp_mux_gen

---
 rtl/disp_mux_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/disp_mux_gen.sv
// Multiplexed 7-segment display scanner with dead-time blanking; optional dimming under DISP_DIM_EN.
// Latency: an/sseg/frame_tick are registered, one cycle behind the slot counter.
// Backpressure: none; free-running scan, inputs are sampled once per digit slot.
module disp_mux_gen #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 12500,
    parameter int DEAD     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*DIGITS-1:0]   in,
    input  logic [DIGITS-1:0]     blank_mask,
`ifdef DISP_DIM_EN
    input  logic [3:0]            bright,
`endif
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_CAP  = CW'(DEAD - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    phase_t            phase;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [7:0]        cap_pat;
    logic              cap_mask;
    logic [DIGITS-1:0] dig_sel;
    logic [7:0]        cur_pat;
    logic              cur_mask;
    logic              lit;
`ifdef DISP_DIM_EN
    logic [3:0]        pwm;
    logic [3:0]        cap_bright;
`endif

    // Explicit compare per digit keeps out-of-range idx values harmless for non-power-of-2 DIGITS.
    always_comb begin
        dig_sel  = '1;
        cur_pat  = 8'hFF;
        cur_mask = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                dig_sel[k] = 1'b0;
                cur_pat    = in[8*k +: 8];
                cur_mask   = blank_mask[k];
            end
        end
    end

`ifdef DISP_DIM_EN
    assign lit = (phase == PH_DRIVE) && !cap_mask && (pwm < cap_bright);
`else
    assign lit = (phase == PH_DRIVE) && !cap_mask;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= PH_BLANK;
            cnt        <= '0;
            idx        <= '0;
            cap_pat    <= 8'hFF;
            cap_mask   <= 1'b1;
            an         <= '1;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
`ifdef DISP_DIM_EN
            pwm        <= 4'd0;
            cap_bright <= 4'd0;
`endif
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            if (cnt == CNT_LAST) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end

            // Pattern is frozen one cycle before DRIVE so mid-slot input changes never tear a digit.
            case (phase)
                PH_BLANK: begin
                    if (cnt == CNT_CAP) begin
                        phase    <= PH_DRIVE;
                        cap_pat  <= cur_pat;
                        cap_mask <= cur_mask;
`ifdef DISP_DIM_EN
                        cap_bright <= bright;
`endif
                    end
                end
                PH_DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        phase <= PH_BLANK;
                    end
                end
                default: phase <= PH_BLANK;
            endcase

`ifdef DISP_DIM_EN
            if (phase == PH_DRIVE) begin
                pwm <= pwm + 4'd1;
            end
`endif

            an         <= lit ? dig_sel : '1;
            sseg       <= ((phase == PH_DRIVE) && !cap_mask) ? cap_pat : 8'hFF;
            frame_tick <= (cnt == CNT_LAST) && (idx == IDX_LAST);
        end
    end

endmodule
